cntr4m_timer_ctrl: RTL and testbench
====================================

Name: cntr4m_timer_ctrl

Overview:
- Control-side master for the 4-mode cascadable counter (mode m, carry-in Ci, carry-out Co, parallel load B, state Q).
- Drives m/Ci/B so that an external counter instance acts as a one-shot or periodic programmable timer.
- Watches Co to detect terminal count and reports tick/done to the system.
- Sits between system control logic and the counter datapath.

Parameters:
- WIDTH, 8, counter width; matches the counter's B/Q width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  start request; sampled only in IDLE.
- stop  in  1  abort request; honoured in any non-IDLE state.
- period  in  WIDTH  terminal distance P; captured on accepted start.
- dir  in  1  0 = count up, 1 = count down; captured on accepted start.
- periodic  in  1  1 = auto-reload after terminal count; captured on accepted start.
- Q  in  WIDTH  counter state; used only by the optional debug feature.
- Co  in  1  counter carry-out.
- m  out  2  counter mode.
- Ci  out  1  counter carry-in (advance enable).
- B  out  WIDTH  counter parallel-load value.
- busy  out  1  high in LOAD and RUN.
- tick  out  1  one-cycle pulse per terminal count.
- done  out  1  one-cycle pulse when a one-shot completes or is stopped.

Behaviour:
- Counter contract:
  - m = 00 hold; 01 up; 10 down; 11 load B.
  - The counter advances only when Ci = 1.
  - Co = Ci & (up ? Q == all-ones : Q == 0).
- Reset: state IDLE; m = 00, Ci = 0, B = 0; busy, tick and done all 0. Reset mid-operation aborts immediately; no done pulse.
- IDLE: m = 00, Ci = 0.
  - start = 1 captures period, dir and periodic, then goes to LOAD.
- LOAD (one cycle): m = 11, Ci = 0.
  - B = dir ? P : ~P (bitwise invert, WIDTH bits), held stable from capture until the next start.
  - Next state is RUN.
- RUN: m = dir ? 10 : 01, Ci = 1.
  - On a cycle where Co = 1: next state is LOAD if periodic, else DONE. tick = 1 on the following cycle.
  - RUN therefore lasts P+1 cycles. The periodic tick interval is P+2 cycles.
- DONE (one cycle): m = 00, Ci = 0, done = 1; next state IDLE.
- stop = 1 in LOAD or RUN: next state DONE; no tick even if Co = 1 in the same cycle (stop wins).
- stop in IDLE: ignored. start outside IDLE: ignored.
- start and stop both high in IDLE: start taken.
- P = 0: RUN lasts 1 cycle; Co is expected in the first RUN cycle.
- P = all-ones: RUN lasts 2^WIDTH cycles.
- All outputs are registered. busy is combinational from state only.

Optional Feature:
- CNTR_TIMER_CHECK_EN defined: a registered flag err (extra output port) sets and stays set until rst if any of these occurs:
  - Co = 1 outside RUN;
  - Q differs from B in the first RUN cycle;
  - RUN exceeds P+1 cycles without Co (internal shadow counter).
- Without the macro: no err port, no shadow counter, Q is unused.

Decomposition:
- Shared package holds:
  - mode constants MODE_HOLD = 2'b00, MODE_UP = 2'b01, MODE_DOWN = 2'b10, MODE_LOAD = 2'b11;
  - state enum IDLE/LOAD/RUN/DONE.
- The package is reused by the counter and its benches.
- Single module. The optional checker is a natural sub-module, cntr4m_timer_chk, instantiated only under the macro.

Test Plan:
- Down one-shot: WIDTH = 8, P = 3, dir = 1, periodic = 0, start pulse → LOAD with B = 8'h03, m = 11; then 4 RUN cycles with m = 10 (Q 3,2,1,0); Co at Q = 0; tick and done each pulse once; back to IDLE with m = 00.
- Up one-shot: P = 3, dir = 0 → B = 8'hFC; Q runs FC→FF over 4 RUN cycles; Co at FF; one tick and one done.
- Periodic down: P = 5, periodic = 1, run 30 cycles → tick every 7 cycles; busy stays high; no done. Then stop → done pulse, then IDLE.
- Boundaries: P = 0 → RUN lasts 1 cycle, one tick. P = 8'hFF, dir = 1 → tick after 256 RUN cycles.
- Collisions:
  - stop coincident with Co → done, no tick.
  - start while busy → ignored; period change while busy has no effect.
  - rst during RUN → next cycle all outputs 0, IDLE.
- Macro build with CNTR_TIMER_CHECK_EN: the model withholds Co in RUN → err rises at cycle P+2 of RUN and stays high until rst.

Source files
------------

// File: rtl/cntr4m_timer_ctrl_pkg.sv
// Shared definitions for the 4-mode cascadable counter and its controllers:
// counter mode encodings, the timer controller state enum and a small helper.
package cntr4m_timer_ctrl_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counting mode used while the timer runs: down when dir = 1, else up.
    function automatic logic [1:0] run_mode(input logic down);
        return down ? MODE_DOWN : MODE_UP;
    endfunction

endpackage

// File: rtl/cntr4m_timer_ctrl_if.sv
// Counter-side bus between the timer controller (master) and a 4-mode
// counter instance (slave): mode, carry-in and load value go out, state and
// carry-out come back.
interface cntr4m_timer_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       m;
    logic             Ci;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic             Co;

    modport master (
        output m,
        output Ci,
        output B,
        input  Q,
        input  Co
    );

    modport slave (
        input  m,
        input  Ci,
        input  B,
        output Q,
        output Co
    );
endinterface

// File: rtl/cntr4m_timer_chk.sv
// Protocol checker for the timer controller. Raises a sticky err flag when
// the counter misbehaves: carry-out outside RUN, wrong state after a load,
// or a RUN phase that outlives its programmed length.
// Only instantiated when CNTR_TIMER_CHECK_EN is defined.
module cntr4m_timer_chk
    import cntr4m_timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  state_t           state,
    input  logic             dir,
    input  logic             stop,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Q,
    input  logic             Co,
    output logic             err
);

    logic [WIDTH-1:0] run_idx_reg;
    logic             err_reg;
    logic [WIDTH-1:0] period_eff;
    logic             violation;

    // The programmed distance is recoverable from the load value and direction.
    assign period_eff = dir ? B : ~B;

    // Index run_idx_reg counts RUN cycles from 0; index P is the last legal one,
    // so reaching it without Co (and without an abort) means RUN overruns.
    always_comb begin
        violation = 1'b0;
        if (Co && (state != RUN))
            violation = 1'b1;
        if ((state == RUN) && (run_idx_reg == '0) && (Q != B))
            violation = 1'b1;
        if ((state == RUN) && (run_idx_reg == period_eff) && !Co && !stop)
            violation = 1'b1;
    end

    // Shadow RUN-length counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_idx_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            if (state == RUN)
                run_idx_reg <= run_idx_reg + 1'b1;
            else
                run_idx_reg <= '0;
            if (violation)
                err_reg <= 1'b1;
        end
    end

    assign err = err_reg;

endmodule

// File: rtl/cntr4m_timer_ctrl.sv
// Timer controller for an external 4-mode counter. Loads the counter with a
// value derived from the period so that carry-out fires exactly P+1 RUN
// cycles later, then reports tick/done. One-shot or periodic operation.
// Optional build macro: CNTR_TIMER_CHECK_EN adds a sticky err output fed by
// the cntr4m_timer_chk protocol checker.
module cntr4m_timer_ctrl
    import cntr4m_timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [WIDTH-1:0]     period,
    input  logic                 dir,
    input  logic                 periodic,
    cntr4m_timer_ctrl_if.master  cnt,
    output logic                 busy,
    output logic                 tick,
    output logic                 done
`ifdef CNTR_TIMER_CHECK_EN
    ,
    output logic                 err
`endif
);

    state_t           state_reg;
    logic             dir_reg;
    logic             periodic_reg;
    logic [1:0]       m_reg;
    logic             ci_reg;
    logic [WIDTH-1:0] b_reg;
    logic             tick_reg;
    logic             done_reg;

    // Controller FSM; every counter-facing output is registered alongside the
    // state so that m/Ci/B always match the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            dir_reg      <= 1'b0;
            periodic_reg <= 1'b0;
            m_reg        <= MODE_HOLD;
            ci_reg       <= 1'b0;
            b_reg        <= '0;
            tick_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    m_reg  <= MODE_HOLD;
                    ci_reg <= 1'b0;
                    if (start) begin
                        dir_reg      <= dir;
                        periodic_reg <= periodic;
                        // Down counts P..0; up counts ~P..all-ones: both P+1 steps.
                        b_reg        <= dir ? period : ~period;
                        state_reg    <= LOAD;
                        m_reg        <= MODE_LOAD;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        state_reg <= DONE;
                        m_reg     <= MODE_HOLD;
                        ci_reg    <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= RUN;
                        m_reg     <= run_mode(dir_reg);
                        ci_reg    <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Abort takes priority over a coincident terminal count.
                        state_reg <= DONE;
                        m_reg     <= MODE_HOLD;
                        ci_reg    <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (cnt.Co) begin
                        tick_reg <= 1'b1;
                        ci_reg   <= 1'b0;
                        if (periodic_reg) begin
                            state_reg <= LOAD;
                            m_reg     <= MODE_LOAD;
                        end else begin
                            state_reg <= DONE;
                            m_reg     <= MODE_HOLD;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    m_reg     <= MODE_HOLD;
                    ci_reg    <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    m_reg     <= MODE_HOLD;
                    ci_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign cnt.m  = m_reg;
    assign cnt.Ci = ci_reg;
    assign cnt.B  = b_reg;
    assign busy   = (state_reg == LOAD) || (state_reg == RUN);
    assign tick   = tick_reg;
    assign done   = done_reg;

`ifdef CNTR_TIMER_CHECK_EN
    cntr4m_timer_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .state (state_reg),
        .dir   (dir_reg),
        .stop  (stop),
        .B     (b_reg),
        .Q     (cnt.Q),
        .Co    (cnt.Co),
        .err   (err)
    );
`endif

endmodule

// File: tb/tb_cntr4m_timer_ctrl.sv
// Directed bench for cntr4m_timer_ctrl with a behavioural 4-mode counter
// attached on the slave side of the counter bus.
module tb_cntr4m_timer_ctrl;
    import cntr4m_timer_ctrl_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] period;
    logic             dir;
    logic             periodic;
    logic             busy;
    logic             tick;
    logic             done;
`ifdef CNTR_TIMER_CHECK_EN
    logic             err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cntr4m_timer_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cntr4m_timer_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .period   (period),
        .dir      (dir),
        .periodic (periodic),
        .cnt      (bus),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
`ifdef CNTR_TIMER_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural counter: load ignores Ci, up/down advance only with Ci.
    logic [WIDTH-1:0] q_model;
    logic             withhold_co;
    logic             co_force;

    always @(posedge clk) begin
        if (bus.m == MODE_LOAD)
            q_model <= bus.B;
        else if (bus.Ci && bus.m == MODE_UP)
            q_model <= q_model + 8'd1;
        else if (bus.Ci && bus.m == MODE_DOWN)
            q_model <= q_model - 8'd1;
    end

    assign bus.Q  = q_model;
    assign bus.Co = co_force | (bus.Ci & ~withhold_co &
                    (((bus.m == MODE_UP) && (q_model == 8'hFF)) ||
                     ((bus.m == MODE_DOWN) && (q_model == 8'h00))));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-shot run: checks the LOAD cycle, the first RUN cycle, RUN length,
    // the tick/done pulse and the return to IDLE.
    task automatic do_oneshot(input string tag, input logic [7:0] p, input logic d,
                              input logic [7:0] exp_b);
        int n;
        period = p; dir = d; periodic = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_load_m"}, bus.m, MODE_LOAD);
        check({tag, "_load_ci"}, bus.Ci, 0);
        check({tag, "_load_b"}, bus.B, exp_b);
        check({tag, "_load_busy"}, busy, 1);
        step();
        check({tag, "_run_m"}, bus.m, d ? MODE_DOWN : MODE_UP);
        check({tag, "_run_q0"}, bus.Q, exp_b);
        n = 1;
        while (bus.Co == 1'b0 && n < 300) begin
            step();
            n++;
        end
        check({tag, "_run_len"}, n, int'(p) + 1);
        step();
        check({tag, "_tick"}, tick, 1);
        check({tag, "_done"}, done, 1);
        check({tag, "_done_m"}, bus.m, MODE_HOLD);
        check({tag, "_done_busy"}, busy, 0);
        step();
        check({tag, "_idle_pulses"}, {tick, done}, 0);
        $display("txn %s: P=%0h dir=%0d run cycles %0d", tag, p, d, n);
    endtask

    initial begin
        int n, first_tick, last_tick, ticks, bad_gap, busy_low, done_seen;

        rst = 1'b1; start = 1'b0; stop = 1'b0; period = '0; dir = 1'b0;
        periodic = 1'b0; withhold_co = 1'b0; co_force = 1'b0;
        step();
        step();
        check("rst_m", bus.m, 0);
        check("rst_ci", bus.Ci, 0);
        check("rst_b", bus.B, 0);
        check("rst_flags", {busy, tick, done}, 0);
        rst = 1'b0;
        step();
        $display("txn reset: outputs idle");

        do_oneshot("down_p3", 8'd3, 1'b1, 8'h03);
        do_oneshot("up_p3", 8'd3, 1'b0, 8'hFC);
        do_oneshot("p0", 8'd0, 1'b0, 8'hFF);
        do_oneshot("pmax", 8'hFF, 1'b1, 8'hFF);

        // Periodic down P=5: LOAD at cycle 0, ticks at 7, 14, 21, 28.
        period = 8'd5; dir = 1'b1; periodic = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        first_tick = -1; last_tick = -1; ticks = 0; bad_gap = 0;
        busy_low = 0; done_seen = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (tick) begin
                if (last_tick >= 0 && (c - last_tick) != 7) bad_gap++;
                if (first_tick < 0) first_tick = c;
                last_tick = c;
                ticks++;
            end
            if (!busy) busy_low++;
            if (done) done_seen++;
        end
        check("per_first_tick", first_tick, 7);
        check("per_ticks", ticks, 4);
        check("per_bad_gap", bad_gap, 0);
        check("per_busy_low", busy_low, 0);
        check("per_done_seen", done_seen, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("per_stop_done", done, 1);
        check("per_stop_tick", tick, 0);
        step();
        check("per_stop_idle", busy, 0);
        $display("txn periodic: %0d ticks, first at cycle %0d", ticks, first_tick);

        // Stop coincident with terminal count: done wins, no tick.
        period = 8'd2; dir = 1'b1; periodic = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (bus.Co == 1'b0 && n < 20) begin
            step();
            n++;
        end
        check("coll_co_seen", bus.Co, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("coll_done", done, 1);
        check("coll_tick", tick, 0);
        step();
        $display("txn stop_vs_co: done without tick");

        // Start and period changes while busy have no effect.
        period = 8'd4; dir = 1'b1; periodic = 1'b0; start = 1'b1;
        step();
        period = 8'd9;
        step();
        n = 1;
        while (bus.Co == 1'b0 && n < 40) begin
            step();
            n++;
        end
        start = 1'b0;
        check("busy_start_len", n, 5);
        check("busy_start_b", bus.B, 8'h04);
        step();
        check("busy_start_done", done, 1);
        step();
        $display("txn start_while_busy: run cycles %0d", n);

        // Stop alone in IDLE is ignored.
        stop = 1'b1;
        step();
        check("idle_stop", {busy, done}, 0);
        // Start and stop together in IDLE: start taken; stop then aborts in LOAD.
        start = 1'b1;
        step();
        start = 1'b0;
        check("both_busy", busy, 1);
        check("both_m", bus.m, MODE_LOAD);
        step();
        stop = 1'b0;
        check("load_stop_done", done, 1);
        check("load_stop_tick", tick, 0);
        step();
        $display("txn start_stop_idle: start accepted, aborted in LOAD");

        // Reset during RUN aborts immediately.
        period = 8'd10; dir = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_run_m_ci_b", {bus.m, bus.Ci, bus.B}, 0);
        check("rst_run_flags", {busy, tick, done}, 0);
        step();
        check("rst_run_no_done", done, 0);
        $display("txn reset_in_run: aborted");

`ifdef CNTR_TIMER_CHECK_EN
        check("chk_err_clean", err, 0);
        // Withhold Co: RUN cycles 1..4 legal for P=3, err visible at cycle 5.
        withhold_co = 1'b1;
        period = 8'd3; dir = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        check("chk_err_at_p1", err, 0);
        step();
        check("chk_err_at_p2", err, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        withhold_co = 1'b0;
        step();
        step();
        check("chk_err_sticky", err, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("chk_err_rst", err, 0);
        co_force = 1'b1;
        step();
        co_force = 1'b0;
        check("chk_err_co_idle", err, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        $display("txn checker: overrun and stray Co flagged");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
